// File: rtl/des_pkg.sv
// Shared DES permutation tables, mode encoding and the table-driven permute function.
package des_pkg;

  typedef enum logic {
    MODE_IP = 1'b0,
    MODE_FP = 1'b1
  } des_mode_e;

  // Entries use 1-based DES numbering: DES bit k lives in vector bit 64-k.
  localparam int unsigned DES_IP_TABLE [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int unsigned DES_FP_TABLE [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  function automatic logic [63:0] des_permute(input logic [63:0] data, input logic mode);
    logic [63:0] res;
    logic [5:0]  src;
    res = '0;
    for (int unsigned j = 0; j < 64; j++) begin
      src = (mode == MODE_FP) ? 6'(64 - DES_FP_TABLE[j]) : 6'(64 - DES_IP_TABLE[j]);
      res[6'(63 - j)] = data[src];
    end
    return res;
  endfunction

endpackage

// File: rtl/des_perm_stage.sv
// One valid/ready register stage of the DES permutation pipeline.
module des_perm_stage #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic             up_mode,
  input  logic [63:0]      up_data,
  input  logic [TAG_W-1:0] up_tag,
  input  logic             down_open,
  output logic             valid,
  output logic             mode,
  output logic [63:0]      data,
  output logic [TAG_W-1:0] tag,
  output logic             open
);

  // Open when empty or when the current content leaves this cycle.
  assign open = !valid | down_open;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      mode  <= 1'b0;
      data  <= '0;
      tag   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (open) begin
      valid <= up_valid;
      if (up_valid) begin
        mode <= up_mode;
        data <= up_data;
        tag  <= up_tag;
      end
    end
  end

endmodule

// File: rtl/des_perm_pipe.sv
// Registered, flow-controlled DES IP / FP permutation with a bubble-collapsing pipeline.
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [63:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_mode,
  output logic [2:0]       occupancy
);

  localparam int unsigned LAST = PIPE_STAGES - 1;

  logic [PIPE_STAGES-1:0] v;
  logic [PIPE_STAGES-1:0] md;
  logic [PIPE_STAGES-1:0] op;
  logic [63:0]            dt [PIPE_STAGES];
  logic [TAG_W-1:0]       tg [PIPE_STAGES];
  logic [63:0]            perm;
  logic                   accept;
  logic                   emit;

  assign perm = des_permute(in_data, in_mode);

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic             up_v;
    logic             up_m;
    logic [63:0]      up_d;
    logic [TAG_W-1:0] up_t;
    logic             dn_open;

    if (s == 0) begin : g_head
      assign up_v = in_valid;
      assign up_m = in_mode;
      assign up_d = perm;
      assign up_t = in_tag;
    end else begin : g_link
      assign up_v = v[s-1];
      assign up_m = md[s-1];
      assign up_d = dt[s-1];
      assign up_t = tg[s-1];
    end

    // Ready chain ripples combinationally from out_ready back to in_ready.
    if (s == LAST) begin : g_tail
      assign dn_open = out_ready;
    end else begin : g_mid
      assign dn_open = op[s+1];
    end

    des_perm_stage #(
      .TAG_W(TAG_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (up_v),
      .up_mode  (up_m),
      .up_data  (up_d),
      .up_tag   (up_t),
      .down_open(dn_open),
      .valid    (v[s]),
      .mode     (md[s]),
      .data     (dt[s]),
      .tag      (tg[s]),
      .open     (op[s])
    );
  end

  assign in_ready  = op[0];
  assign out_valid = v[LAST];
  assign out_mode  = md[LAST];
  assign out_data  = dt[LAST];
  assign out_tag   = tg[LAST];

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (accept && !emit) begin
      occupancy <= occupancy + 3'd1;
    end else if (emit && !accept) begin
      occupancy <= occupancy - 3'd1;
    end
  end

endmodule
